bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shared-bus responder in front of the memory. Receives the CPU bus request (breq_) and the
//  DMA controller's bus request, and returns grants (bgrt_ to CPU, dma_gnt_ to DMA).
//  Muxes the owner's addr/wdata/rw_ onto the memory port.
//  Caps DMA tenure when the CPU is waiting. Inserts one dead cycle on every ownership change.
// PARAMETERS
//  ADDR_W        10  memory address width (= BUS_ADDR_WIDTH)
//  DATA_W         8  data width (= DATA_WIDTH)
//  MAX_DMA_CYC   16  max consecutive DMA-owned cycles while breq_ is asserted (>=2)
// PORTS
//  clk         in   1       single system clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  breq_       in   1       CPU bus request, active-low
//  bgrt_       out  1       CPU bus grant, active-low
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_rw_     in   1       CPU direction: 1=read, 0=write
//  dma_req_    in   1       DMA bus request, active-low
//  dma_gnt_    out  1       DMA bus grant, active-low
//  dma_addr    in   ADDR_W  DMA address
//  dma_wdata   in   DATA_W  DMA write data
//  dma_rw_     in   1       DMA direction: 1=read, 0=write
//  eop_        in   1       DMA end-of-process, active-low; releases the bus
//  dma_preempt out  1       1-cycle pulse: DMA tenure cut by MAX_DMA_CYC
//  mem_en      out  1       memory access enable, active-high
//  mem_rw_     out  1       memory direction: 1=read, 0=write
//  mem_addr    out  ADDR_W  memory address
//  mem_wdata   out  DATA_W  memory write data
// BEHAVIOUR
//  Reset (async, any time): state=IDLE; bgrt_=1; dma_gnt_=1; dma_preempt=0; mem_en=0;
//   mem_rw_=1; mem_addr=0; mem_wdata=0; burst_cnt=0; last_owner=CPU.
//   An asserted reset mid-tenure drops the grant immediately, without waiting for the next edge.
//  States: IDLE, CPU_OWN, DMA_OWN, HANDOVER. Grants and dma_preempt are registered (state-decoded).
//  IDLE:
//   - breq_=0 -> CPU_OWN. CPU has priority on simultaneous requests.
//   - else dma_req_=0 -> DMA_OWN.
//   - Grant is visible 1 cycle after the request is sampled.
//  CPU_OWN:
//   - bgrt_=0. Stays while breq_=0.
//   - breq_=1 sampled -> HANDOVER; last_owner=CPU. The CPU is never preempted.
//  DMA_OWN:
//   - dma_gnt_=0. burst_cnt increments each cycle, saturating at MAX_DMA_CYC-1.
//   - dma_req_=1 or eop_=0 sampled -> HANDOVER. eop_ wins over any preempt that cycle.
//   - breq_=0 && burst_cnt==MAX_DMA_CYC-1 -> HANDOVER, dma_preempt=1 for that one cycle.
//   - On exit: last_owner=DMA, burst_cnt=0.
//   - A DMA that keeps dma_req_=0 re-requests and re-wins later.
//  HANDOVER (exactly 1 cycle):
//   - Both grants high; mem_en=0.
//   - Next state is round-robin: a requester other than last_owner wins.
//   - Else the sole requester wins, even if it was the last owner.
//   - Else -> IDLE.
//  Memory mux (combinational from state):
//   - CPU_OWN: mem_*=cpu_*, mem_en=1.
//   - DMA_OWN: mem_*=dma_*, mem_en=1.
//   - IDLE/HANDOVER: mem_en=0, mem_rw_=1 (read-safe), mem_addr=0, mem_wdata=0.
//  Invariants:
//   - bgrt_ and dma_gnt_ are never both 0.
//   - mem_en=0 whenever both grants are 1.
//   - No write can occur in the cycle after a grant change.
//  MAX_DMA_CYC only bounds DMA while the CPU waits; with breq_=1 a DMA burst is unlimited.
// TESTING
//  1 Reset, breq_=0 from cyc 0, write 10'h150<=8'h99, then read 10'h150:
//    -> bgrt_=0 at cyc 1; mem_en=1, mem_rw_=0, mem_addr=150, mem_wdata=99 on write cycle.
//  2 breq_ and dma_req_ both fall in same cycle from IDLE:
//    -> bgrt_=0 next cycle, dma_gnt_ stays 1.
//    -> breq_ release -> 1 HANDOVER cycle -> dma_gnt_=0.
//  3 DMA owns; breq_=0 asserted; MAX_DMA_CYC=16:
//    -> dma_preempt pulse and dma_gnt_=1 when burst_cnt=15.
//    -> HANDOVER, then bgrt_=0; DMA regains after CPU releases.
//  4 DMA burst 10'h150->10'h160, eop_=0 on 2nd transfer cycle:
//    -> dma_gnt_=1 next cycle, no preempt pulse; mem_en=0 in HANDOVER.
//  5 reset=1 asserted mid-DMA between clock edges:
//    -> dma_gnt_=1 and mem_en=0 immediately; IDLE after release.
//  6 Random breq_/dma_req_/eop_ for 10k cycles:
//    -> grants never both 0; each ownership change has exactly 1 dead cycle.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared-bus signal bundle between the CPU/DMA requesters, the arbiter and the memory port.
// The arbiter connects through the slave modport; requesters and memory use master.
interface bus_arbiter_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
);
   logic              breq_;
   logic              bgrt_;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_rw_;
   logic              dma_req_;
   logic              dma_gnt_;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_rw_;
   logic              eop_;
   logic              dma_preempt;
   logic              mem_en;
   logic              mem_rw_;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;

   modport slave (
      input  breq_, cpu_addr, cpu_wdata, cpu_rw_,
      input  dma_req_, dma_addr, dma_wdata, dma_rw_, eop_,
      output bgrt_, dma_gnt_, dma_preempt,
      output mem_en, mem_rw_, mem_addr, mem_wdata
   );

   modport master (
      output breq_, cpu_addr, cpu_wdata, cpu_rw_,
      output dma_req_, dma_addr, dma_wdata, dma_rw_, eop_,
      input  bgrt_, dma_gnt_, dma_preempt,
      input  mem_en, mem_rw_, mem_addr, mem_wdata
   );
endinterface

// File: rtl/bus_arbiter.sv
// CPU/DMA shared-bus arbiter: grants one owner at a time, muxes it onto the memory port,
// caps DMA tenure while the CPU waits and inserts one dead cycle on every ownership change.
module bus_arbiter #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 8,
   parameter int MAX_DMA_CYC = 16
) (
   input  logic         clk,
   input  logic         reset,
   bus_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CPU_OWN  = 2'd1,
      DMA_OWN  = 2'd2,
      HANDOVER = 2'd3
   } state_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DMA = 1'b1
   } owner_t;

   localparam int              CNT_W    = (MAX_DMA_CYC > 2) ? $clog2(MAX_DMA_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_DMA_CYC - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic [CNT_W-1:0]  r_burstCnt;
   logic [CNT_W-1:0]  w_nextBurstCnt;
   owner_t            r_lastOwner;
   owner_t            w_nextLastOwner;
   logic              r_dmaPreempt;
   logic              w_preemptNow;

   logic              w_cpuWants;
   logic              w_dmaWants;
   logic              w_eopSeen;

   logic              w_memEn;
   logic              w_memRw;
   logic [ADDR_W-1:0] w_memAddr;
   logic [DATA_W-1:0] w_memWdata;

   assign w_cpuWants = ~bus.breq_;
   assign w_dmaWants = ~bus.dma_req_;
   assign w_eopSeen  = ~bus.eop_;

   // State, tenure counter, round-robin history and the registered preempt pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_burstCnt   <= '0;
         r_lastOwner  <= OWNER_CPU;
         r_dmaPreempt <= 1'b0;
      end else begin
         r_state      <= w_nextState;
         r_burstCnt   <= w_nextBurstCnt;
         r_lastOwner  <= w_nextLastOwner;
         r_dmaPreempt <= w_preemptNow;
      end
   end

   // Next-state logic; every exit from an owned state passes through HANDOVER.
   always_comb begin
      w_nextState     = r_state;
      w_nextBurstCnt  = r_burstCnt;
      w_nextLastOwner = r_lastOwner;
      w_preemptNow    = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_cpuWants) begin
               w_nextState = CPU_OWN;
            end else if (w_dmaWants) begin
               w_nextState = DMA_OWN;
            end
         end

         CPU_OWN: begin
            if (!w_cpuWants) begin
               w_nextState     = HANDOVER;
               w_nextLastOwner = OWNER_CPU;
            end
         end

         DMA_OWN: begin
            if (r_burstCnt != CNT_LAST) begin
               w_nextBurstCnt = r_burstCnt + 1'b1;
            end
            // A voluntary release or end-of-process takes precedence over the cap.
            if (!w_dmaWants || w_eopSeen) begin
               w_nextState     = HANDOVER;
               w_nextLastOwner = OWNER_DMA;
               w_nextBurstCnt  = '0;
            end else if (w_cpuWants && (r_burstCnt == CNT_LAST)) begin
               w_nextState     = HANDOVER;
               w_nextLastOwner = OWNER_DMA;
               w_nextBurstCnt  = '0;
               w_preemptNow    = 1'b1;
            end
         end

         HANDOVER: begin
            if ((r_lastOwner == OWNER_CPU) && w_dmaWants) begin
               w_nextState = DMA_OWN;
            end else if ((r_lastOwner == OWNER_DMA) && w_cpuWants) begin
               w_nextState = CPU_OWN;
            end else if (w_cpuWants) begin
               w_nextState = CPU_OWN;
            end else if (w_dmaWants) begin
               w_nextState = DMA_OWN;
            end else begin
               w_nextState = IDLE;
            end
         end

         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Memory port follows the owner; idle and dead cycles park it on a harmless read of 0.
   always_comb begin
      w_memEn    = 1'b0;
      w_memRw    = 1'b1;
      w_memAddr  = '0;
      w_memWdata = '0;
      case (r_state)
         CPU_OWN: begin
            w_memEn    = 1'b1;
            w_memRw    = bus.cpu_rw_;
            w_memAddr  = bus.cpu_addr;
            w_memWdata = bus.cpu_wdata;
         end
         DMA_OWN: begin
            w_memEn    = 1'b1;
            w_memRw    = bus.dma_rw_;
            w_memAddr  = bus.dma_addr;
            w_memWdata = bus.dma_wdata;
         end
         default: begin
            w_memEn = 1'b0;
         end
      endcase
   end

   assign bus.bgrt_       = (r_state != CPU_OWN);
   assign bus.dma_gnt_    = (r_state != DMA_OWN);
   assign bus.dma_preempt = r_dmaPreempt;
   assign bus.mem_en      = w_memEn;
   assign bus.mem_rw_     = w_memRw;
   assign bus.mem_addr    = w_memAddr;
   assign bus.mem_wdata   = w_memWdata;

   // Exclusive grants and a quiet memory port whenever nobody holds the bus.
   assert property (@(posedge clk) disable iff (reset) (bus.bgrt_ || bus.dma_gnt_));
   assert property (@(posedge clk) disable iff (reset)
                    ((bus.bgrt_ && bus.dma_gnt_) |-> !bus.mem_en));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations,
// then randomized requests compared every cycle against an ownership-level model.
module tb_bus_arbiter;

   localparam int ADDR_W      = 10;
   localparam int DATA_W      = 8;
   localparam int MAX_DMA_CYC = 16;

   logic clk;
   logic reset;
   int   checks   = 0;
   int   failures = 0;

   bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busIf ();

   bus_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .MAX_DMA_CYC(MAX_DMA_CYC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(busIf.slave)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: who owns the bus (0 nobody, 1 CPU, 2 DMA), whether the current
   // empty cycle is a dead cycle after a tenure, the previous owner, cycles owned by DMA.
   int mOwner     = 0;
   int mLastOwner = 1;
   int mTenure    = 0;
   bit mInGap     = 1'b0;
   bit mPreempt   = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic breqN, input logic dmaReqN, input logic eopN);
      busIf.breq_    = breqN;
      busIf.dma_req_ = dmaReqN;
      busIf.eop_     = eopN;
   endtask

   // Move to the drive point 2ns after the next rising edge.
   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Ownership model: stepped on each rising edge from the inputs the bus presented.
   always @(posedge clk or posedge reset) begin
      bit cpuWants;
      bit dmaWants;
      bit favourDma;
      if (reset) begin
         mOwner     = 0;
         mLastOwner = 1;
         mTenure    = 0;
         mInGap     = 1'b0;
         mPreempt   = 1'b0;
      end else begin
         cpuWants = (busIf.breq_ == 1'b0);
         dmaWants = (busIf.dma_req_ == 1'b0);
         mPreempt = 1'b0;
         if (mOwner == 1) begin
            if (!cpuWants) begin
               mOwner = 0; mInGap = 1'b1; mLastOwner = 1;
            end
         end else if (mOwner == 2) begin
            mTenure++;
            if (!dmaWants || busIf.eop_ == 1'b0) begin
               mOwner = 0; mInGap = 1'b1; mLastOwner = 2;
            end else if (cpuWants && mTenure >= MAX_DMA_CYC) begin
               mOwner = 0; mInGap = 1'b1; mLastOwner = 2; mPreempt = 1'b1;
            end
         end else begin
            favourDma = mInGap && (mLastOwner == 1);
            mInGap    = 1'b0;
            if (cpuWants && dmaWants) mOwner = favourDma ? 2 : 1;
            else if (cpuWants)        mOwner = 1;
            else if (dmaWants)        mOwner = 2;
            else                      mOwner = 0;
            if (mOwner == 2) mTenure = 0;
         end
      end
   end

   // Every falling edge: all outputs against the model, plus the bus invariants.
   always @(negedge clk) begin
      logic              expRw;
      logic [ADDR_W-1:0] expAddr;
      logic [DATA_W-1:0] expData;
      expRw   = 1'b1;
      expAddr = '0;
      expData = '0;
      if (mOwner == 1) begin
         expRw = busIf.cpu_rw_; expAddr = busIf.cpu_addr; expData = busIf.cpu_wdata;
      end else if (mOwner == 2) begin
         expRw = busIf.dma_rw_; expAddr = busIf.dma_addr; expData = busIf.dma_wdata;
      end
      checkOutput("bgrt_",       busIf.bgrt_,       (mOwner != 1));
      checkOutput("dma_gnt_",    busIf.dma_gnt_,    (mOwner != 2));
      checkOutput("dma_preempt", busIf.dma_preempt, mPreempt);
      checkOutput("mem_en",      busIf.mem_en,      (mOwner != 0));
      checkOutput("mem_rw_",     busIf.mem_rw_,     expRw);
      checkOutput("mem_addr",    busIf.mem_addr,    expAddr);
      checkOutput("mem_wdata",   busIf.mem_wdata,   expData);
      checkOutput("grantExclusive", (busIf.bgrt_ | busIf.dma_gnt_), 1'b1);
      if (busIf.bgrt_ && busIf.dma_gnt_)
         checkOutput("memQuietNoGrant", busIf.mem_en, 1'b0);
   end

   initial begin
      reset = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      busIf.cpu_addr  = '0; busIf.cpu_wdata = '0; busIf.cpu_rw_ = 1'b1;
      busIf.dma_addr  = '0; busIf.dma_wdata = '0; busIf.dma_rw_ = 1'b1;
      waitCycles(2);
      checkOutput("resetBgrt",   busIf.bgrt_,       1'b1);
      checkOutput("resetDmaGnt", busIf.dma_gnt_,    1'b1);
      checkOutput("resetMemEn",  busIf.mem_en,      1'b0);
      checkOutput("resetMemRw",  busIf.mem_rw_,     1'b1);
      checkOutput("resetPreempt",busIf.dma_preempt, 1'b0);

      // CPU write of 8'h99 to 10'h150, then a read of the same address.
      reset = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1);
      busIf.cpu_addr = 10'h150; busIf.cpu_wdata = 8'h99; busIf.cpu_rw_ = 1'b0;
      waitCycles(1);
      checkOutput("cpuGrantCyc1", busIf.bgrt_,     1'b0);
      checkOutput("cpuWriteEn",   busIf.mem_en,    1'b1);
      checkOutput("cpuWriteRw",   busIf.mem_rw_,   1'b0);
      checkOutput("cpuWriteAddr", busIf.mem_addr,  10'h150);
      checkOutput("cpuWriteData", busIf.mem_wdata, 8'h99);
      busIf.cpu_rw_ = 1'b1;
      waitCycles(1);
      checkOutput("cpuReadRw",   busIf.mem_rw_,  1'b1);
      checkOutput("cpuReadAddr", busIf.mem_addr, 10'h150);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(1);
      checkOutput("cpuReleaseDead", busIf.mem_en, 1'b0);
      waitCycles(1);

      // Simultaneous requests from IDLE: CPU first, DMA after one dead cycle.
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(1);
      checkOutput("tieCpuWins", busIf.bgrt_,    1'b0);
      checkOutput("tieDmaWait", busIf.dma_gnt_, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(1);
      checkOutput("tieDeadBgrt",  busIf.bgrt_,    1'b1);
      checkOutput("tieDeadDma",   busIf.dma_gnt_, 1'b1);
      checkOutput("tieDeadMemEn", busIf.mem_en,   1'b0);
      waitCycles(1);
      checkOutput("tieDmaGets", busIf.dma_gnt_, 1'b0);

      // CPU waits on a DMA burst: cut after 16 owned cycles with a preempt pulse.
      applyStimulus(1'b0, 1'b0, 1'b1);
      waitCycles(15);
      checkOutput("capStillDma",   busIf.dma_gnt_,    1'b0);
      checkOutput("capNoPulseYet", busIf.dma_preempt, 1'b0);
      waitCycles(1);
      checkOutput("capDmaDropped", busIf.dma_gnt_,    1'b1);
      checkOutput("capPulse",      busIf.dma_preempt, 1'b1);
      checkOutput("capDeadBgrt",   busIf.bgrt_,       1'b1);
      waitCycles(1);
      checkOutput("capCpuGets",    busIf.bgrt_,       1'b0);
      checkOutput("capPulseGone",  busIf.dma_preempt, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(2);
      checkOutput("capDmaRegains", busIf.dma_gnt_,    1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(2);

      // DMA burst from 10'h150 ended by eop_ on its second transfer cycle.
      applyStimulus(1'b1, 1'b0, 1'b1);
      busIf.dma_addr = 10'h150; busIf.dma_wdata = 8'h3c; busIf.dma_rw_ = 1'b0;
      waitCycles(1);
      checkOutput("eopFirstAddr", busIf.mem_addr, 10'h150);
      checkOutput("eopFirstRw",   busIf.mem_rw_,  1'b0);
      busIf.dma_addr = 10'h151;
      waitCycles(1);
      checkOutput("eopSecondAddr", busIf.mem_addr, 10'h151);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitCycles(1);
      checkOutput("eopDmaDropped", busIf.dma_gnt_,    1'b1);
      checkOutput("eopNoPreempt",  busIf.dma_preempt, 1'b0);
      checkOutput("eopDeadMemEn",  busIf.mem_en,      1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(1);

      // Asynchronous reset in the middle of a DMA tenure.
      applyStimulus(1'b1, 1'b0, 1'b1);
      waitCycles(1);
      checkOutput("arstDmaOwns", busIf.dma_gnt_, 1'b0);
      #1 reset = 1'b1;
      #1;
      checkOutput("arstDmaGnt", busIf.dma_gnt_, 1'b1);
      checkOutput("arstMemEn",  busIf.mem_en,   1'b0);
      waitCycles(1);
      reset = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1);
      waitCycles(1);
      checkOutput("arstIdleBgrt", busIf.bgrt_,    1'b1);
      checkOutput("arstIdleDma",  busIf.dma_gnt_, 1'b1);

      // Randomized traffic; the compare process checks every cycle.
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(7) == 0)  busIf.breq_    = ~busIf.breq_;
         if ($urandom_range(15) == 0) busIf.dma_req_ = ~busIf.dma_req_;
         busIf.eop_      = ($urandom_range(39) != 0);
         busIf.cpu_addr  = 10'($urandom);
         busIf.cpu_wdata = 8'($urandom);
         busIf.cpu_rw_   = 1'($urandom);
         busIf.dma_addr  = 10'($urandom);
         busIf.dma_wdata = 8'($urandom);
         busIf.dma_rw_   = 1'($urandom);
         waitCycles(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
